// File: rtl/hazard_pkg.sv
// Shared hazard-control definitions: RV32 opcode constants, controller state type
// and register-usage decode helpers used by detection and forwarding logic.
package hazard_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;

  typedef enum logic [2:0] {
    RUN,
    FLUSH,
    LOAD_STALL,
    MEM_WAIT,
    DBG_HALT
  } hz_state_t;

  function automatic logic op_uses_rs1(input logic [6:0] op);
    return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
  endfunction

  function automatic logic op_uses_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_S) || (op == OP_B);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational source-register decode of the ID instruction and load-use compare
// against the EX destination register.
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] instr_i,
  input  logic [4:0]      ex_rd_i,
  input  logic            ex_is_load_i,
  output logic            load_use_o
);

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       unused_instr_bits;

  assign opcode   = instr_i[6:0];
  assign rs1      = instr_i[19:15];
  assign rs2      = instr_i[24:20];
  assign uses_rs1 = op_uses_rs1(opcode);
  assign uses_rs2 = op_uses_rs2(opcode);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign load_use_o = ex_is_load_i && (ex_rd_i != 5'd0) &&
                      ((uses_rs1 && (rs1 == ex_rd_i)) ||
                       (uses_rs2 && (rs2 == ex_rd_i)));

  assign unused_instr_bits = ^{instr_i[XLEN-1:25], instr_i[14:7]};

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Halt/flush sequencer for the IF/ID and ID/EX registers (load-use, branch flush,
// memory freeze, debug park). Optional counters enabled by HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int LOAD_LAT    = 1,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] id_instr,
  input  logic [4:0]      ex_rd,
  input  logic            ex_is_load,
  input  logic            ex_branch_taken,
  input  logic            mem_busy,
  input  logic            dbg_halt_req,
  input  logic            dbg_resume,
  output logic            halt_if,
  output logic            halt_id,
  output logic            flush_id,
  output logic            flush_ex,
  output logic            dbg_halted,
  output logic            mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
`endif
);

  localparam logic [7:0] TIMEOUT_Q = 8'(MEM_TIMEOUT);
  localparam logic [2:0] STALL_INIT = 3'(LOAD_LAT - 1);

  hz_state_t  state_q, state_d;
  logic [2:0] stall_cnt_q, stall_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_err_q, mem_err_d;
  logic       dbg_halted_q, dbg_halted_d;

  logic       load_use;
  logic       halt_c;
  logic       flush_id_c;
  logic       flush_ex_c;
  logic       branch_flush_c;

  hazard_detect #(
    .XLEN (XLEN)
  ) u_detect (
    .instr_i      (id_instr),
    .ex_rd_i      (ex_rd),
    .ex_is_load_i (ex_is_load),
    .load_use_o   (load_use)
  );

  always_comb begin
    state_d        = state_q;
    stall_cnt_d    = stall_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    halt_c         = 1'b0;
    flush_id_c     = 1'b0;
    flush_ex_c     = 1'b0;
    branch_flush_c = 1'b0;

    case (state_q)
      // A cycle in MEM_WAIT without mem_busy behaves exactly like RUN
      RUN, MEM_WAIT: begin
        if (mem_busy) begin
          halt_c  = 1'b1;
          state_d = MEM_WAIT;
          if (state_q == RUN)
            wait_cnt_d = 8'd1;
          else if (wait_cnt_q != TIMEOUT_Q)
            wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
          wait_cnt_d = 8'd0;
          state_d    = RUN;
          if (ex_branch_taken) begin
            flush_id_c     = 1'b1;
            flush_ex_c     = 1'b1;
            branch_flush_c = 1'b1;
            state_d        = FLUSH;
          end else if (load_use) begin
            halt_c     = 1'b1;
            flush_ex_c = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d     = LOAD_STALL;
              stall_cnt_d = STALL_INIT;
            end
          end else if (dbg_halt_req) begin
            halt_c  = 1'b1;
            state_d = DBG_HALT;
          end
        end
      end
      // Second flush cycle kills the wrong-path fetch already in flight
      FLUSH: begin
        flush_id_c = 1'b1;
        if (mem_busy) begin
          halt_c     = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else begin
          state_d = RUN;
        end
      end
      LOAD_STALL: begin
        halt_c     = 1'b1;
        flush_ex_c = 1'b1;
        if (mem_busy) begin
          state_d     = MEM_WAIT;
          wait_cnt_d  = 8'd1;
          stall_cnt_d = 3'd0;
        end else begin
          stall_cnt_d = stall_cnt_q - 3'd1;
          if (stall_cnt_q == 3'd1)
            state_d = RUN;
        end
      end
      DBG_HALT: begin
        halt_c = 1'b1;
        if (dbg_resume)
          state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    mem_err_d    = mem_err_q | (wait_cnt_d == TIMEOUT_Q);
    dbg_halted_d = (state_d == DBG_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      stall_cnt_q  <= 3'd0;
      wait_cnt_q   <= 8'd0;
      mem_err_q    <= 1'b0;
      dbg_halted_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      stall_cnt_q  <= stall_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      mem_err_q    <= mem_err_d;
      dbg_halted_q <= dbg_halted_d;
    end
  end

  // Mealy outputs are gated so they read 0 the moment reset asserts
  assign halt_if    = rst_n & halt_c;
  assign halt_id    = rst_n & halt_c;
  assign flush_id   = rst_n & flush_id_c;
  assign flush_ex   = rst_n & flush_ex_c;
  assign dbg_halted = dbg_halted_q;
  assign mem_err    = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CNT_W-1:0] stall_cycles_q;
  logic [CNT_W-1:0] flush_events_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (halt_c)
        stall_cycles_q <= stall_cycles_q + CNT_ONE;
      if (branch_flush_c)
        flush_events_q <= flush_events_q + CNT_ONE;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed check of pipeline_hazard_ctrl (LOAD_LAT=1 and LOAD_LAT=3
// instances) against a cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] id_instr;
  logic [4:0]  ex_rd;
  logic        ex_is_load, ex_branch_taken, mem_busy, dbg_halt_req, dbg_resume;

  logic hif[2], hid[2], fid[2], fex[2], dbgh[2], merr[2];
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] sc[2], fe[2];
`endif

  int    n_cmp = 0;
  int    n_bad = 0;
  string ph = "init";
  int    hcnt = 0;

  int          lat[2];
  int          m_rem[2], m_mw[2];
  bit          m_fl[2], m_dbg[2], m_err[2];
  logic [31:0] m_sc[2], m_fe[2];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.XLEN(32), .LOAD_LAT(1), .MEM_TIMEOUT(TO), .CNT_W(32)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy), .dbg_halt_req(dbg_halt_req),
    .dbg_resume(dbg_resume), .halt_if(hif[0]), .halt_id(hid[0]), .flush_id(fid[0]),
    .flush_ex(fex[0]), .dbg_halted(dbgh[0]), .mem_err(merr[0])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(sc[0]), .flush_events(fe[0])
`endif
  );

  pipeline_hazard_ctrl #(.XLEN(32), .LOAD_LAT(3), .MEM_TIMEOUT(TO), .CNT_W(32)) dut_l3 (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy), .dbg_halt_req(dbg_halt_req),
    .dbg_resume(dbg_resume), .halt_if(hif[1]), .halt_id(hid[1]), .flush_id(fid[1]),
    .flush_ex(fex[1]), .dbg_halted(dbgh[1]), .mem_err(merr[1])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(sc[1]), .flush_events(fe[1])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outv(input int i);
    return {26'd0, hif[i], hid[i], fid[i], fex[i], dbgh[i], merr[i]};
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [2:0] f3);
    return {7'd0, rs2, rs1, f3, rd, op};
  endfunction

  // Register-read rules of RV32: U-type and JAL read nothing; R/S/B read two sources
  function automatic bit ref_load_use(input logic [31:0] ins, input logic [4:0] rd,
                                      input logic ld);
    logic [6:0] op;
    bit r1, r2;
    op = ins[6:0];
    r1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6f);
    r2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
    return ld && rd != 0 && ((r1 && ins[19:15] == rd) || (r2 && ins[24:20] == rd));
  endfunction

  task automatic step();
    bit lu;
    @(negedge clk);
    lu = ref_load_use(id_instr, ex_rd, ex_is_load);
    for (int i = 0; i < 2; i++) begin
      bit h, f1, f2, e_dh, e_err;
      logic [31:0] e_sc, e_fe;
      h = 0; f1 = 0; f2 = 0;
      e_dh = m_dbg[i]; e_err = m_err[i]; e_sc = m_sc[i]; e_fe = m_fe[i];
      if (!rst_n) begin
        chk($sformatf("%s_rst[%0d]", ph, i), outv(i), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk($sformatf("%s_rst_cnt[%0d]", ph, i), sc[i] | fe[i], 32'd0);
`endif
        m_rem[i] = 0; m_mw[i] = 0; m_fl[i] = 0; m_dbg[i] = 0; m_err[i] = 0;
        m_sc[i] = 0; m_fe[i] = 0;
      end else begin
        if (m_dbg[i]) begin
          h = 1;
          if (dbg_resume) m_dbg[i] = 0;
        end else if (m_fl[i]) begin
          f1 = 1; m_fl[i] = 0;
          if (mem_busy) begin h = 1; m_mw[i] = 1; end
        end else if (m_rem[i] > 0) begin
          h = 1; f2 = 1;
          if (mem_busy) begin m_rem[i] = 0; m_mw[i] = 1; end
          else m_rem[i]--;
        end else if (mem_busy) begin
          h = 1;
          m_mw[i] = (m_mw[i] == 0) ? 1 : ((m_mw[i] < TO) ? m_mw[i] + 1 : TO);
          if (m_mw[i] == TO) m_err[i] = 1;
        end else begin
          m_mw[i] = 0;
          if (ex_branch_taken) begin
            f1 = 1; f2 = 1; m_fl[i] = 1; m_fe[i] = m_fe[i] + 1;
          end else if (lu) begin
            h = 1; f2 = 1; m_rem[i] = lat[i] - 1;
          end else if (dbg_halt_req) begin
            h = 1; m_dbg[i] = 1;
          end
        end
        chk($sformatf("%s_out[%0d]", ph, i), outv(i), {26'd0, h, h, f1, f2, e_dh, e_err});
`ifdef HAZARD_PERF_CNT_EN
        chk($sformatf("%s_stall_cnt[%0d]", ph, i), sc[i], e_sc);
        chk($sformatf("%s_flush_cnt[%0d]", ph, i), fe[i], e_fe);
`endif
        m_sc[i] = m_sc[i] + 32'(h);
      end
    end
    if (hid[1]) hcnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [4:0] rd, input logic ld,
                       input logic br, input logic mb, input logic dq, input logic dr);
    id_instr = ins; ex_rd = rd; ex_is_load = ld; ex_branch_taken = br;
    mem_busy = mb; dbg_halt_req = dq; dbg_resume = dr;
    step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(32'h13, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] add_x1_x5_x2, sw_x5, lui_x5;
    logic [6:0] ops[8];
    int busy_left;
    lat[0] = 1; lat[1] = 3;
    ops[0] = 7'h33; ops[1] = 7'h23; ops[2] = 7'h63; ops[3] = 7'h13;
    ops[4] = 7'h03; ops[5] = 7'h37; ops[6] = 7'h17; ops[7] = 7'h6f;
    add_x1_x5_x2 = mk(7'h33, 5'd1, 5'd5, 5'd2, 3'd0);
    sw_x5        = mk(7'h23, 5'd0, 5'd2, 5'd5, 3'd2);
    lui_x5       = mk(7'h37, 5'd5, 5'd5, 5'd5, 3'd0);

    rst_n = 1'b0;
    ph = "reset";
    drive(32'h13, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(32'h13, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(1);

    ph = "t1_loaduse";
    drive(add_x1_x5_x2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    ph = "t1_rd0";
    drive(add_x1_x5_x2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);

    ph = "t3_branch";
    drive(32'h13, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
`ifdef HAZARD_PERF_CNT_EN
    chk("t6_stall_cycles", sc[0], 32'd1);
    chk("t6_flush_events", fe[0], 32'd1);
`endif
    ph = "t3_branch_lu";
    drive(add_x1_x5_x2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);

    ph = "t2_sw";
    hcnt = 0;
    drive(sw_x5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("t2_halt_run_len", 32'(hcnt), 32'd3);
    ph = "t2_lui";
    hcnt = 0;
    drive(lui_x5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("t2_lui_no_stall", 32'(hcnt), 32'd0);

    ph = "t4_membusy";
    for (int k = 0; k < 70; k++) drive(32'h13, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ph = "t4_release";
    idle(3);
    chk("t4_mem_err_sticky", 32'(merr[1]), 32'd1);

    ph = "t5_dbg";
    drive(32'h13, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(32'h13, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    drive(32'h13, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    drive(32'h13, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_rst0", outv(0), 32'd0);
    chk("t5_async_rst1", outv(1), 32'd0);
    ph = "t5_in_reset";
    idle(1);
    rst_n = 1'b1;
    idle(1);

    ph = "rand";
    busy_left = 0;
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] ins;
      logic mb;
      ins = mk(ops[$urandom_range(7)], 5'($urandom_range(7)), 5'($urandom_range(7)),
               5'($urandom_range(7)), 3'($urandom));
      ins[31:25] = 7'($urandom);
      if (busy_left == 0 && $urandom_range(99) < 6) busy_left = $urandom_range(12, 1);
      if (k == 1500) busy_left = 80;
      mb = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      drive(ins, 5'($urandom_range(7)), 1'($urandom_range(99) < 45),
            1'($urandom_range(99) < 12), mb, 1'($urandom_range(99) < 3),
            1'($urandom_range(99) < 15));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
